// File: rtl/data_mem_responder_pkg.sv
// Shared types for the data-memory responder: bus sizes, access-size encoding
// and the responder state machine encoding.
package data_mem_responder_pkg;

  parameter int DATA_BUS          = 32;
  parameter int RAM_ADDRESS_WIDTH = 18;

  typedef enum logic [1:0] {
    BYTE     = 2'b00,
    HALFWORD = 2'b01,
    WORD     = 2'b10
  } byte_format;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RD_LO = 3'd1,
    ST_RD_HI = 3'd2,
    ST_WR_LO = 3'd3,
    ST_WR_HI = 3'd4,
    ST_RESP  = 3'd5
  } mem_state;

  // Byte-lane mask of an access starting at lane 0; 2'b11 behaves as a word.
  function automatic logic [3:0] size_mask(input logic [1:0] sz);
    case (sz)
      BYTE:     return 4'b0001;
      HALFWORD: return 4'b0011;
      default:  return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_responder_ram.sv
// Word-wide single-port RAM with per-byte write strobes and a registered
// (one-cycle latency) read port. Contents are not reset.
module data_ram_bank #(
  parameter int DEPTH      = 65536,
  parameter int DATA_WIDTH = 32,
  localparam int AW        = $clog2(DEPTH),
  localparam int NB        = DATA_WIDTH / 8
) (
  input  logic                  i_clk,
  input  logic                  i_en,
  input  logic                  i_we,
  input  logic [NB-1:0]         i_be,
  input  logic [AW-1:0]         i_addr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rdata;

  // Read data holds its last value while the port is idle or writing.
  always_ff @(posedge i_clk) begin
    if (i_en) begin
      if (i_we) begin
        for (int unsigned b = 0; b < NB; b++) begin
          if (i_be[b]) begin
            r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
          end
        end
      end else begin
        r_rdata <= r_mem[i_addr];
      end
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/data_mem_responder.sv
// Load/store responder: one access per handshake on a byte-strobed word RAM,
// word-crossing accesses split into lo/hi RAM cycles, loads sign/zero-extended.
module data_mem_responder #(
  parameter int DATA_WIDTH        = data_mem_responder_pkg::DATA_BUS,
  parameter int RAM_ADDRESS_WIDTH = data_mem_responder_pkg::RAM_ADDRESS_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic                         req_write,
  input  logic [RAM_ADDRESS_WIDTH-1:0] req_addr,
  input  logic [1:0]                   req_size,
  input  logic                         req_unsigned,
  input  logic [DATA_WIDTH-1:0]        req_wdata,
  output logic                         resp_valid,
  input  logic                         resp_ready,
  output logic [DATA_WIDTH-1:0]        resp_rdata
);
  import data_mem_responder_pkg::*;

  localparam int WORD_AW = RAM_ADDRESS_WIDTH - 2;
  localparam int DEPTH   = 1 << WORD_AW;

  mem_state                     r_state;
  logic                         r_req_ready;
  logic                         r_resp_valid;
  logic [DATA_WIDTH-1:0]        r_resp_rdata;
  logic                         r_write;
  logic                         r_unsigned;
  logic [1:0]                   r_size;
  logic [RAM_ADDRESS_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0]        r_wdata;
  logic [DATA_WIDTH-1:0]        r_lo_word;

  logic [1:0]              w_off;
  logic [WORD_AW-1:0]      w_idx_lo;
  logic [WORD_AW-1:0]      w_idx_hi;
  logic [7:0]              w_be8;
  logic [2*DATA_WIDTH-1:0] w_wshift;
  logic                    w_split;

  logic                    w_ram_en;
  logic                    w_ram_we;
  logic [3:0]              w_ram_be;
  logic [WORD_AW-1:0]      w_ram_addr;
  logic [DATA_WIDTH-1:0]   w_ram_wdata;
  logic [DATA_WIDTH-1:0]   w_ram_rdata;

  logic [DATA_WIDTH-1:0]   w_lo;
  logic [DATA_WIDTH-1:0]   w_pair;
  logic [DATA_WIDTH-1:0]   w_load;

  // Lanes 0-3 of the shifted mask/data target word w, lanes 4-7 target w+1.
  assign w_off    = r_addr[1:0];
  assign w_idx_lo = r_addr[RAM_ADDRESS_WIDTH-1:2];
  assign w_idx_hi = w_idx_lo + {{(WORD_AW-1){1'b0}}, 1'b1};
  assign w_be8    = {4'b0000, size_mask(r_size)} << w_off;
  assign w_wshift = {{DATA_WIDTH{1'b0}}, r_wdata} << {w_off, 3'b000};
  assign w_split  = |w_be8[7:4];

  always_comb begin
    w_ram_en    = 1'b0;
    w_ram_we    = 1'b0;
    w_ram_be    = '0;
    w_ram_addr  = w_idx_lo;
    w_ram_wdata = w_wshift[DATA_WIDTH-1:0];
    case (r_state)
      ST_RD_LO: w_ram_en = 1'b1;
      ST_RD_HI: begin
        w_ram_en   = 1'b1;
        w_ram_addr = w_idx_hi;
      end
      ST_WR_LO: begin
        w_ram_en = 1'b1;
        w_ram_we = 1'b1;
        w_ram_be = w_be8[3:0];
      end
      ST_WR_HI: begin
        w_ram_en    = 1'b1;
        w_ram_we    = 1'b1;
        w_ram_be    = w_be8[7:4];
        w_ram_addr  = w_idx_hi;
        w_ram_wdata = w_wshift[2*DATA_WIDTH-1:DATA_WIDTH];
      end
      default: ;
    endcase
  end

  data_ram_bank #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ram (
    .i_clk   (clk),
    .i_en    (w_ram_en),
    .i_we    (w_ram_we),
    .i_be    (w_ram_be),
    .i_addr  (w_ram_addr),
    .i_wdata (w_ram_wdata),
    .o_rdata (w_ram_rdata)
  );

  // In the first RESP cycle the RAM port still holds the last word read:
  // the lo word for a single access, the hi word after a split one.
  always_comb begin
    w_lo   = w_split ? r_lo_word : w_ram_rdata;
    w_pair = DATA_WIDTH'({w_ram_rdata, w_lo} >> {w_off, 3'b000});
    case (r_size)
      BYTE: w_load = r_unsigned ? {{(DATA_WIDTH-8){1'b0}}, w_pair[7:0]}
                                : {{(DATA_WIDTH-8){w_pair[7]}}, w_pair[7:0]};
      HALFWORD: w_load = r_unsigned ? {{(DATA_WIDTH-16){1'b0}}, w_pair[15:0]}
                                    : {{(DATA_WIDTH-16){w_pair[15]}}, w_pair[15:0]};
      default: w_load = w_pair;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_write      <= 1'b0;
      r_unsigned   <= 1'b0;
      r_size       <= '0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_lo_word    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid && r_req_ready) begin
            r_write     <= req_write;
            r_unsigned  <= req_unsigned;
            r_size      <= req_size;
            r_addr      <= req_addr;
            r_wdata     <= req_wdata;
            r_req_ready <= 1'b0;
            r_state     <= req_write ? ST_WR_LO : ST_RD_LO;
          end
        end
        ST_RD_LO: r_state <= w_split ? ST_RD_HI : ST_RESP;
        ST_RD_HI: begin
          r_lo_word <= w_ram_rdata;
          r_state   <= ST_RESP;
        end
        ST_WR_LO: r_state <= w_split ? ST_WR_HI : ST_RESP;
        ST_WR_HI: r_state <= ST_RESP;
        ST_RESP: begin
          if (!r_resp_valid) begin
            r_resp_valid <= 1'b1;
            r_resp_rdata <= r_write ? '0 : w_load;
          end else if (resp_ready) begin
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            r_req_ready  <= 1'b1;
            r_state      <= ST_IDLE;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_req_ready <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready  = r_req_ready;
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed scenarios plus randomized accesses
// checked against a byte-addressed memory model.
module tb_data_mem_responder;

  localparam int AW    = 18;
  localparam int AMASK = (1 << AW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [1:0]    req_size = '0;
  logic          req_unsigned = 1'b0;
  logic [31:0]   req_wdata = '0;
  logic          resp_valid;
  logic          resp_ready = 1'b1;
  logic [31:0]   resp_rdata;

  int n_total = 0;
  int n_bad   = 0;

  logic [7:0] m_mem [int];

  data_mem_responder #(
    .DATA_WIDTH        (32),
    .RAM_ADDRESS_WIDTH (AW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_addr     (req_addr),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_rdata   (resp_rdata)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  function automatic int size_n(input logic [1:0] s);
    case (s)
      2'd0:    return 1;
      2'd1:    return 2;
      default: return 4;
    endcase
  endfunction

  function automatic void model_store(input int addr, input logic [1:0] s, input logic [31:0] d);
    for (int k = 0; k < size_n(s); k++) m_mem[(addr + k) & AMASK] = d[8*k +: 8];
  endfunction

  function automatic logic [31:0] model_load(input int addr, input logic [1:0] s, input logic u);
    int          n = size_n(s);
    logic [31:0] v = '0;
    for (int k = 0; k < n; k++) v[8*k +: 8] = m_mem[(addr + k) & AMASK];
    if (n < 4 && !u && v[8*n-1]) begin
      for (int k = 8*n; k < 32; k++) v[k] = 1'b1;
    end
    return v;
  endfunction

  task automatic drive_req(input logic w, input int addr, input logic [1:0] s,
                           input logic u, input logic [31:0] d);
    @(negedge clk);
    req_valid    = 1'b1;
    req_write    = w;
    req_addr     = AW'(addr);
    req_size     = s;
    req_unsigned = u;
    req_wdata    = d;
  endtask

  // Waits for acceptance and the response; retires it when resp_ready is high.
  task automatic finish_req(output logic [31:0] rd, output int lat);
    int guard = 0;
    while (!req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) check_val("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    while (!resp_valid && lat < 10) begin
      @(posedge clk);
      #1 lat++;
    end
    rd = resp_rdata;
    if (resp_ready) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_op(input logic w, input int addr, input logic [1:0] s, input logic u,
                       input logic [31:0] d, output logic [31:0] rd);
    logic [31:0] exp;
    int          lat;
    exp = w ? 32'd0 : model_load(addr, s, u);
    drive_req(w, addr, s, u, d);
    finish_req(rd, lat);
    check_val(w ? "lat_st" : "lat_ld", 32'(lat), (((addr & 3) + size_n(s)) > 4) ? 32'd3 : 32'd2);
    check_val(w ? "rdata_st" : "rdata_ld", rd, exp);
    if (w) model_store(addr, s, d);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rd;
    logic [31:0] held;
    int          lat;
    int          addr;
    logic        w;
    logic [1:0]  s;

    #12;
    check_val("rst_req_ready", 32'(req_ready), 32'd1);
    check_val("rst_resp_valid", 32'(resp_valid), 32'd0);
    check_val("rst_resp_rdata", resp_rdata, 32'd0);
    @(negedge clk) rst_n = 1'b1;

    do_op(1'b1, 'h10, 2'd2, 1'b0, 32'hDEADBEEF, rd);
    do_op(1'b0, 'h10, 2'd2, 1'b0, 32'h0, rd);
    check_val("lw_10", rd, 32'hDEADBEEF);
    do_op(1'b0, 'h13, 2'd0, 1'b0, 32'h0, rd);
    check_val("lb_13", rd, 32'hFFFFFFDE);
    do_op(1'b0, 'h13, 2'd0, 1'b1, 32'h0, rd);
    check_val("lbu_13", rd, 32'h000000DE);
    do_op(1'b0, 'h12, 2'd1, 1'b0, 32'h0, rd);
    check_val("lh_12", rd, 32'hFFFFDEAD);

    do_op(1'b1, 'h20, 2'd2, 1'b0, 32'h01020304, rd);
    do_op(1'b1, 'h24, 2'd2, 1'b0, 32'h05060708, rd);
    do_op(1'b1, 'h23, 2'd1, 1'b0, 32'h0000A1B2, rd);
    do_op(1'b0, 'h20, 2'd2, 1'b0, 32'h0, rd);
    check_val("split_lo_word", rd, 32'hB2020304);
    do_op(1'b0, 'h24, 2'd2, 1'b0, 32'h0, rd);
    check_val("split_hi_word", rd, 32'h050607A1);
    do_op(1'b0, 'h23, 2'd1, 1'b1, 32'h0, rd);
    check_val("lhu_23", rd, 32'h0000A1B2);

    do_op(1'b1, 'h3FFFC, 2'd2, 1'b0, 32'hCAFEF00D, rd);
    do_op(1'b1, 'h0, 2'd2, 1'b0, 32'h0BADC0DE, rd);
    do_op(1'b1, 'h3FFFE, 2'd3, 1'b0, 32'h11223344, rd);
    do_op(1'b0, 'h3FFFC, 2'd2, 1'b0, 32'h0, rd);
    check_val("wrap_top_word", rd, 32'h3344F00D);
    do_op(1'b0, 'h0, 2'd2, 1'b0, 32'h0, rd);
    check_val("wrap_word0", rd, 32'h0BAD1122);
    do_op(1'b0, 'h3FFFE, 2'd2, 1'b0, 32'h0, rd);
    check_val("wrap_lw", rd, 32'h11223344);

    // Back-pressure with a second request waiting.
    resp_ready = 1'b0;
    drive_req(1'b0, 'h10, 2'd2, 1'b0, 32'h0);
    finish_req(held, lat);
    check_val("bp_lat", 32'(lat), 32'd2);
    check_val("bp_rdata", held, 32'hDEADBEEF);
    drive_req(1'b0, 'h13, 2'd0, 1'b0, 32'h0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check_val("bp_valid_held", 32'(resp_valid), 32'd1);
      check_val("bp_rdata_held", resp_rdata, 32'hDEADBEEF);
      check_val("bp_req_ready", 32'(req_ready), 32'd0);
    end
    @(negedge clk) resp_ready = 1'b1;
    @(posedge clk);
    #1 check_val("bp_retired", 32'(resp_valid), 32'd0);
    finish_req(rd, lat);
    check_val("bp_second_lat", 32'(lat), 32'd2);
    check_val("bp_second_rdata", rd, 32'hFFFFFFDE);

    // Reset during the hi-word write of a split store.
    do_op(1'b1, 'h40, 2'd2, 1'b0, 32'hA0A1A2A3, rd);
    do_op(1'b1, 'h44, 2'd2, 1'b0, 32'hB0B1B2B3, rd);
    drive_req(1'b1, 'h41, 2'd2, 1'b0, 32'h55667788);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_val("mid_rst_req_ready", 32'(req_ready), 32'd1);
    check_val("mid_rst_resp_valid", 32'(resp_valid), 32'd0);
    check_val("mid_rst_resp_rdata", resp_rdata, 32'd0);
    for (int k = 0; k < 3; k++) m_mem[('h41 + k) & AMASK] = 8'h88 + 8'(k) * 8'hEF;
    @(negedge clk) rst_n = 1'b1;
    do_op(1'b0, 'h40, 2'd2, 1'b0, 32'h0, rd);
    check_val("torn_lo_word", rd, 32'h667788A3);
    do_op(1'b0, 'h44, 2'd2, 1'b0, 32'h0, rd);
    check_val("torn_hi_word", rd, 32'hB0B1B2B3);

    // Randomized accesses over a mid-memory window and the wrapping top region.
    for (int a = 'h100; a < 'h140; a += 4) do_op(1'b1, a, 2'd2, 1'b0, $urandom, rd);
    for (int a = 'h3FFF0; a < 'h40000; a += 4) do_op(1'b1, a, 2'd2, 1'b0, $urandom, rd);
    for (int a = 0; a < 'h10; a += 4) do_op(1'b1, a, 2'd2, 1'b0, $urandom, rd);
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 2) == 0) addr = ('h3FFF8 + int'($urandom_range(0, 15))) & AMASK;
      else addr = 'h100 + int'($urandom_range(0, 60));
      w = 1'($urandom_range(0, 1));
      s = 2'($urandom_range(0, 3));
      do_op(w, addr, s, 1'($urandom_range(0, 1)), $urandom, rd);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Memory-side responder for the CPU load/store port: accepts one byte/halfword/word access per handshake, performs it on an internal byte-enabled word RAM, and returns load data sign- or zero-extended. Misaligned accesses that cross a word boundary are split into two sequential RAM accesses by a small state machine. Sits between the pipeline's memory stage and data storage, and is the receiving end of the `byte_format`-sized request the memory stage issues.

## Interface
- `DATA_WIDTH`, 32, data/word width; only 32 is supported.
- `RAM_ADDRESS_WIDTH`, 18, byte-address width; RAM depth is 2^(RAM_ADDRESS_WIDTH-2) words.
- `clk`  in  1  single clock; all state changes on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  high only in IDLE; request accepted when `req_valid && req_ready`.
- `req_write`  in  1  1 = store, 0 = load.
- `req_addr`  in  RAM_ADDRESS_WIDTH  byte address.
- `req_size`  in  2  `byte_format`: Byte, HalfWord, Word; encoding 2'b11 treated as Word.
- `req_unsigned`  in  1  loads only: zero-extend (LBU/LHU) instead of sign-extend.
- `req_wdata`  in  DATA_WIDTH  store data, LSB-aligned.
- `resp_valid`  out  1  response present; held until accepted.
- `resp_ready`  in  1  response accepted when `resp_valid && resp_ready`.
- `resp_rdata`  out  DATA_WIDTH  extended load data; 0 for store responses.

## Operation
- States: IDLE, RD_LO, RD_HI, WR_LO, WR_HI, RESP. Request fields captured into registers at the accept edge; inputs ignored afterwards.
- Size n = 1/2/4 bytes; offset o = addr[1:0]; word index w = addr[RAM_ADDRESS_WIDTH-1:2]. Split when o+n > 4 (halfword at o=3; word at o≠0).
- Little-endian: request byte k maps to byte address addr+k. Lo word w gets lanes o..min(3,o+n-1); hi word (w+1) mod DEPTH gets lanes 0..o+n-5 (index wraps at top of memory).
- IDLE → RD_LO (load) or WR_LO (store) on accept.
- RD_LO: read word w. → RD_HI if split, else RESP.
- RD_HI: read word w+1. → RESP.
- WR_LO: write word w with lane strobes. → WR_HI if split, else RESP.
- WR_HI: write word w+1 with lane strobes. → RESP.
- RESP: `resp_valid`=1; → IDLE when `resp_ready`. A request is not accepted in the same cycle a response retires (one outstanding access).
- Load assembly: shift {hi,lo} right by 8·o, keep n bytes; Byte sign bit 7, HalfWord bit 15 unless `req_unsigned`; Word ignores `req_unsigned`.

## Timing
- Reset: state IDLE, `req_ready`=1, `resp_valid`=0, `resp_rdata`=0; RAM contents not reset.
- RAM: synchronous read, 1-cycle latency; write on edge with byte strobes; one access per cycle.
- Accept edge T0. Aligned/non-split: `resp_valid` rises at T0+2. Split: T0+3. `resp_rdata` stable while `resp_valid` high.
- Store data visible to any load accepted after the store's response retires.
- Reset asserted mid-operation: return to reset values immediately; a completed WR_LO write persists, a pending WR_HI is dropped (torn store accepted).
- `req_valid` while not IDLE: no effect, no queuing.

## Structure
- Shared types package: add `mem_state` enum (6 states, 3 bits) and use existing `byte_format`, `DATA_BUS`, `RAM_ADDRESS_WIDTH`; no new local constants for size encodings.
- One sub-module: `data_ram_bank` — word-wide, byte-strobed, sync-read single-port RAM (DEPTH, DATA_WIDTH parameters). Lane-strobe generation, load alignment and extension stay in the top module.

## Test plan
- Store Word 0xDEADBEEF @0x10, load Word @0x10 → 0xDEADBEEF, `resp_valid` at T0+2 both times.
- Load Byte @0x13 signed → 0xFFFFFFDE; unsigned → 0x000000DE; HalfWord @0x12 signed → 0xFFFFDEAD.
- Store HalfWord 0xA1B2 @0x23 (split): word 0x20 lane 3 = 0xB2, word 0x24 lane 0 = 0xA1; other lanes unchanged; response at T0+3; load HalfWord unsigned @0x23 → 0x0000A1B2.
- Store Word 0x11223344 @0x3FFFE (top, split, wraps): bytes 0x44,0x33 at top word lanes 2–3, 0x22,0x11 at word 0 lanes 0–1; load back → 0x11223344.
- Hold `resp_ready`=0 for 5 cycles with new `req_valid` asserted: `resp_valid`/`resp_rdata` stable, `req_ready`=0, second request accepted only after retire.
- Assert `rst_n`=0 in WR_HI of a split store: outputs at reset values asynchronously; lo-word bytes written, hi-word unchanged; next request served normally.
